console_byte_bridge: RTL and testbench

Buffered byte router between the console's character sources and sinks. Keyboard ASCII bytes are queued and drained into the UART transmitter under a proper start/busy handshake, never issuing a start while the transmitter is busy. UART-received bytes are queued and presented to the terminal/display engine on a valid/ready stream, with optional local echo of keystrokes. It sits between the PS/2 scan-code converter, the UART transceiver pair and the VGA text engine, and exports counters and sticky flags for the 7-segment debug displays.

---
 rtl/console_pkg.sv | 18 +
 rtl/console_sync_fifo.sv | 68 ++++++
 rtl/console_byte_bridge.sv | 173 +++++++++++++++++
 tb/tb_console_byte_bridge.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared definitions for the console byte bridge: TX handshake states,
// byte width and the bit positions of the sticky debug flags.
package console_pkg;

    localparam int BYTE_W = 8;

    localparam int FLAG_TX_OVF    = 0;
    localparam int FLAG_RX_OVF    = 1;
    localparam int FLAG_ECHO_DROP = 2;
    localparam int FLAG_W         = 3;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_ARMED   = 2'd1,
        TX_SENDING = 2'd2
    } tx_state_t;

endpackage

// File: rtl/console_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Storage is not reset; only pointers and level are.
module console_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic [AW:0]      level_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == FULL_LEVEL);
    assign level   = level_reg;
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a write when a read frees the slot this cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr_reg];

    always_comb begin
        level_next = level_reg;
        case ({do_push, do_pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_next;
        end
    end

endmodule

// File: rtl/console_byte_bridge.sv
// Keyboard->UART and UART->terminal byte router with a start/busy handshake
// toward the transmitter, optional local echo and sticky debug flags.
module console_byte_bridge
    import console_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int LOCAL_ECHO  = 0,
    parameter int ARM_TIMEOUT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        key_valid,
    input  logic [DATA_WIDTH-1:0]       key_data,
    output logic                        tx_start,
    output logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        tx_busy,
    input  logic                        rx_ready,
    input  logic [DATA_WIDTH-1:0]       rx_data,
    output logic                        term_valid,
    output logic [DATA_WIDTH-1:0]       term_data,
    input  logic                        term_ready,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [2:0]                  flags,
    input  logic                        clear_flags
);

    localparam int CW = $clog2(ARM_TIMEOUT) + 1;
    localparam logic [CW-1:0] ARM_LAST = CW'(ARM_TIMEOUT - 1);
    localparam logic ECHO_EN = (LOCAL_ECHO != 0);

    logic [DATA_WIDTH-1:0] tx_head;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_pop;
    logic [DATA_WIDTH-1:0] rx_head;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_push;
    logic [DATA_WIDTH-1:0] rx_push_data;
    logic                  term_pop;
    logic                  echo_req;

    tx_state_t             state_reg;
    tx_state_t             state_next;
    logic [CW-1:0]         arm_cnt_reg;
    logic [CW-1:0]         arm_cnt_next;
    logic                  tx_start_reg;
    logic                  tx_start_next;
    logic [DATA_WIDTH-1:0] tx_data_reg;
    logic [DATA_WIDTH-1:0] tx_data_next;

    logic [FLAG_W-1:0]     flag_evt;
    logic [FLAG_W-1:0]     flags_reg;

    console_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (key_valid),
        .push_data (key_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    always_comb begin
        state_next    = state_reg;
        arm_cnt_next  = arm_cnt_reg;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data_reg;
        tx_pop        = 1'b0;
        case (state_reg)
            TX_IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    tx_pop        = 1'b1;
                    tx_data_next  = tx_head;
                    tx_start_next = 1'b1;
                    arm_cnt_next  = '0;
                    state_next    = TX_ARMED;
                end
            end
            TX_ARMED: begin
                // A transmitter that never acknowledges must not stall the queue.
                if (tx_busy) begin
                    state_next = TX_SENDING;
                end else if (arm_cnt_reg == ARM_LAST) begin
                    state_next = TX_IDLE;
                end else begin
                    arm_cnt_next = arm_cnt_reg + 1'b1;
                end
            end
            TX_SENDING: begin
                if (!tx_busy) begin
                    state_next = TX_IDLE;
                end
            end
            default: state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= TX_IDLE;
            arm_cnt_reg  <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            arm_cnt_reg  <= arm_cnt_next;
            tx_start_reg <= tx_start_next;
            tx_data_reg  <= tx_data_next;
        end
    end

    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;

    // UART bytes take priority; an echo only goes in when the slot is free.
    assign term_pop     = term_valid & term_ready;
    assign echo_req     = ECHO_EN & key_valid;
    assign rx_push      = rx_ready | (echo_req & (~rx_full | term_pop));
    assign rx_push_data = rx_ready ? rx_data : key_data;

    console_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_push_data),
        .pop       (term_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

    assign term_valid = ~rx_empty;
    assign term_data  = rx_head;

    always_comb begin
        flag_evt                 = '0;
        flag_evt[FLAG_TX_OVF]    = key_valid & tx_full & ~tx_pop;
        flag_evt[FLAG_RX_OVF]    = rx_ready & rx_full & ~term_pop;
        flag_evt[FLAG_ECHO_DROP] = echo_req & (rx_ready | (rx_full & ~term_pop));
    end

    // Set has priority over clear so an event coincident with a clear is kept.
    generate
        for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_flag
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    flags_reg[gi] <= 1'b0;
                end else if (flag_evt[gi]) begin
                    flags_reg[gi] <= 1'b1;
                end else if (clear_flags) begin
                    flags_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign flags = flags_reg;

endmodule

// File: tb/tb_console_byte_bridge.sv
// Randomized scoreboard bench for console_byte_bridge with local echo enabled:
// a queue-based model predicts transmitter starts, terminal bytes, levels and flags.
module tb_console_byte_bridge;

    localparam int DW     = 8;
    localparam int TXD    = 16;
    localparam int RXD    = 16;
    localparam int ECHO   = 1;
    localparam int ARM_TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          key_valid = 1'b0;
    logic [DW-1:0] key_data = '0;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_busy = 1'b0;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          term_valid;
    logic [DW-1:0] term_data;
    logic          term_ready = 1'b0;
    logic [4:0]    tx_level;
    logic [4:0]    rx_level;
    logic [2:0]    flags;
    logic          clear_flags = 1'b0;

    always #5 clk = ~clk;

    console_byte_bridge #(
        .DATA_WIDTH  (DW),
        .TX_DEPTH    (TXD),
        .RX_DEPTH    (RXD),
        .LOCAL_ECHO  (ECHO),
        .ARM_TIMEOUT (ARM_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_data    (key_data),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .term_valid  (term_valid),
        .term_data   (term_data),
        .term_ready  (term_ready),
        .tx_level    (tx_level),
        .rx_level    (rx_level),
        .flags       (flags),
        .clear_flags (clear_flags)
    );

    typedef struct packed {
        logic [7:0] data;
        int         cyc;
    } tx_exp_t;

    // Reference model state
    logic [7:0] tq[$];
    tx_exp_t    exp_tx[$];
    logic [7:0] exp_term[$];
    int         m_phase = 0;     // 0 waiting for work, 1 awaiting busy, 2 transmitter busy
    int         arm_until = 0;
    int         rcount = 0;
    logic [2:0] m_flags = '0;
    logic [7:0] m_last = '0;
    int         cyc = 0;
    bit         done = 1'b0;

    int n_vec = 0;
    int n_mis = 0;

    // Model: evaluates each clock edge from the inputs that edge applied.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst) begin
                tq.delete();
                exp_tx.delete();
                exp_term.delete();
                m_phase = 0;
                rcount  = 0;
                m_flags = '0;
                m_last  = '0;
            end else begin
                automatic logic [2:0] evt = '0;
                automatic bit start = (m_phase == 0) && (tq.size() > 0) && !tx_busy;
                if (m_phase == 0) begin
                    if (start) begin
                        m_phase   = 1;
                        arm_until = cyc + ARM_TO;
                    end
                end else if (m_phase == 1) begin
                    if (tx_busy) m_phase = 2;
                    else if (cyc == arm_until) m_phase = 0;
                end else begin
                    if (!tx_busy) m_phase = 0;
                end
                if (start) begin
                    m_last = tq.pop_front();
                    exp_tx.push_back('{data: m_last, cyc: cyc});
                end
                if (key_valid) begin
                    if (tq.size() < TXD) tq.push_back(key_data);
                    else evt[0] = 1'b1;
                end
                if (term_ready && rcount > 0) rcount--;
                if (rx_ready) begin
                    if (rcount < RXD) begin
                        exp_term.push_back(rx_data);
                        rcount++;
                    end else begin
                        evt[1] = 1'b1;
                    end
                end
                if (ECHO != 0 && key_valid) begin
                    if (rx_ready || rcount >= RXD) begin
                        evt[2] = 1'b1;
                    end else begin
                        exp_term.push_back(key_data);
                        rcount++;
                    end
                end
                m_flags = (clear_flags ? 3'b000 : m_flags) | evt;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the model between clock edges.
    initial begin
        bit prev_start = 1'b0;
        while (!done) begin
            @(negedge clk or negedge rst);
            if (done) break;
            if (!rst) begin
                #1;
                prev_start = 1'b0;
                chk("rst_tx_start", int'(tx_start), 0);
                chk("rst_tx_data", int'(tx_data), 0);
                chk("rst_term_valid", int'(term_valid), 0);
                chk("rst_term_data", int'(term_data), 0);
                chk("rst_tx_level", int'(tx_level), 0);
                chk("rst_rx_level", int'(rx_level), 0);
                chk("rst_flags", int'(flags), 0);
            end else begin
                while (exp_tx.size() > 0 && exp_tx[0].cyc < cyc) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL tx_start_missing: got none, expected start of 0x%0h at cycle %0d", exp_tx[0].data, exp_tx[0].cyc);
                    void'(exp_tx.pop_front());
                end
                if (tx_start) begin
                    if (exp_tx.size() == 0) begin
                        n_vec++;
                        n_mis++;
                        $display("FAIL tx_start_spurious: got start of 0x%0h, expected none (cycle %0d)", tx_data, cyc);
                    end else begin
                        automatic tx_exp_t e = exp_tx.pop_front();
                        chk("tx_start_data", int'(tx_data), int'(e.data));
                        $display("tx  byte 0x%02h started at cycle %0d", tx_data, cyc);
                    end
                end
                chk("tx_start_back_to_back", int'(prev_start & tx_start), 0);
                prev_start = tx_start;
                chk("tx_data_hold", int'(tx_data), int'(m_last));
                chk("tx_level", int'(tx_level), tq.size());
                chk("rx_level", int'(rx_level), rcount);
                chk("flags", int'(flags), int'(m_flags));
                chk("term_valid", int'(term_valid), int'(rcount != 0));
                if (term_valid) begin
                    if (exp_term.size() == 0) begin
                        n_vec++;
                        n_mis++;
                        $display("FAIL term_data_unexpected: got 0x%0h, expected no byte (cycle %0d)", term_data, cyc);
                    end else begin
                        chk("term_data", int'(term_data), int'(exp_term[0]));
                        if (term_ready) begin
                            $display("term byte 0x%02h accepted at cycle %0d", term_data, cyc);
                            void'(exp_term.pop_front());
                        end
                    end
                end else begin
                    chk("term_data_empty", int'(term_data), 0);
                end
            end
        end
        chk("tx_starts_outstanding", exp_tx.size(), 0);
        chk("final_tx_level", int'(tx_level), 0);
        chk("final_rx_level", int'(rx_level), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int u_wait = -1;
    int u_len  = 0;

    // Transmitter stand-in: after each start, busy rises late or never.
    task automatic uart_step();
        if (tx_start) begin
            u_wait = $urandom_range(0, ARM_TO + 1);
            u_len  = $urandom_range(1, 6);
        end
        if (u_wait > 0) begin
            u_wait--;
            tx_busy = 1'b0;
        end else if (u_len > 0) begin
            u_len--;
            tx_busy = 1'b1;
        end else begin
            tx_busy = 1'b0;
        end
    endtask

    // Driver
    initial begin
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Single key, then a long busy period with nothing else queued
        key_valid = 1'b1; key_data = 8'h41;
        tick();
        key_valid = 1'b0;
        tick();
        tx_busy = 1'b1;
        repeat (10) tick();
        tx_busy = 1'b0;
        repeat (3) tick();

        // 17 back-to-back keys while busy: one overflows, rest sent in order
        tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            key_valid = 1'b1;
            key_data  = 8'(8'h30 + i);
            tick();
        end
        key_valid  = 1'b0;
        tick();
        tx_busy    = 1'b0;
        term_ready = 1'b1;
        repeat (90) tick();
        term_ready  = 1'b0;
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;

        // Two received bytes held, then drained
        rx_ready = 1'b1; rx_data = 8'h55;
        tick();
        rx_data = 8'hAA;
        tick();
        rx_ready = 1'b0;
        repeat (2) tick();
        term_ready = 1'b1;
        repeat (3) tick();
        term_ready = 1'b0;

        // Echo collides with a received byte
        key_valid = 1'b1; key_data = 8'h61;
        rx_ready  = 1'b1; rx_data  = 8'h62;
        tick();
        key_valid  = 1'b0;
        rx_ready   = 1'b0;
        term_ready = 1'b1;
        repeat (8) tick();
        term_ready = 1'b0;

        // Reset while sending with bytes queued
        key_valid = 1'b1; key_data = 8'h70;
        tick();
        key_valid = 1'b0;
        tick();
        tx_busy = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1;
            key_data  = 8'(8'h71 + i);
            tick();
        end
        key_valid = 1'b0;
        tick();
        #1 rst = 1'b0;
        tick();
        tick();
        rst     = 1'b1;
        tx_busy = 1'b0;
        key_valid = 1'b1; key_data = 8'h21;
        tick();
        key_valid = 1'b1; key_data = 8'h22;
        tick();
        key_valid  = 1'b0;
        term_ready = 1'b1;
        repeat (12) tick();

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            uart_step();
            key_valid   = ($urandom_range(0, 2) == 0);
            key_data    = 8'($urandom);
            rx_ready    = ($urandom_range(0, 3) == 0);
            rx_data     = 8'($urandom);
            term_ready  = (n < 400) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            clear_flags = ($urandom_range(0, 39) == 0);
            tick();
        end

        // Drain both directions
        key_valid   = 1'b0;
        rx_ready    = 1'b0;
        clear_flags = 1'b0;
        term_ready  = 1'b1;
        for (int n = 0; n < 320; n++) begin
            uart_step();
            tick();
        end
        tx_busy = 1'b0;
        repeat (12) tick();
        done = 1'b1;
    end

endmodule
